// File: rtl/imem_loader_responder.sv
// Instruction-memory responder for the fetch stage with a byte-serial program loader.
// Loader assembles little-endian words, stalls the pipeline while loading and returns NOPs.
module imem_loader_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 10,
    parameter logic [31:0] NOP_INSN    = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       im_addr,
    output logic [31:0]       im_dout,
    output logic              addr_fault,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_stall,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_overflow,
    output logic [ADDR_W:0]   load_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [31:0]       mem [DEPTH_WORDS];
    state_t            state, state_nxt;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   word_idx;
    logic [31:0]       shreg;
    logic [31:0]       word_asm;
    logic              overflow_q;
    logic              accept;
    logic              word_end;
    logic              has_room;
    logic [ADDR_W-1:0] rd_idx;

    assign rd_idx     = im_addr[ADDR_W+1:2];
    assign addr_fault = (im_addr[1:0] != 2'b00) || (im_addr[63:ADDR_W+2] != '0);
    assign im_dout    = (addr_fault || state != IDLE) ? NOP_INSN : mem[rd_idx];

    assign accept   = load_valid && load_ready;
    assign word_end = accept && (byte_cnt == 2'd3 || load_last);
    // word_idx stops at DEPTH_WORDS, so its top bit alone marks a full memory
    assign has_room = !word_idx[ADDR_W];

    assign load_count    = word_idx;
    assign load_overflow = overflow_q;

    // Current byte goes into lane byte_cnt; lanes above it stay zero (padding on load_last)
    always_comb begin
        word_asm = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < 32'(byte_cnt))
                word_asm[i*8 +: 8] = shreg[i*8 +: 8];
            else if (i == 32'(byte_cnt))
                word_asm[i*8 +: 8] = load_byte;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        load_busy  = 1'b0;
        cpu_stall  = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (load_start)
                    state_nxt = LOAD;
            end
            LOAD: begin
                load_ready = 1'b1;
                load_busy  = 1'b1;
                cpu_stall  = 1'b1;
                if (load_valid && load_last)
                    state_nxt = DONE;
            end
            DONE: begin
                load_done = 1'b1;
                cpu_stall = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            word_idx   <= '0;
            shreg      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && load_start) begin
                byte_cnt   <= '0;
                word_idx   <= '0;
                shreg      <= '0;
                overflow_q <= 1'b0;
            end else if (accept) begin
                if (word_end) begin
                    byte_cnt <= '0;
                    shreg    <= '0;
                    if (has_room)
                        word_idx <= word_idx + (ADDR_W+1)'(1);
                    else
                        overflow_q <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                    shreg    <= word_asm;
                end
            end
        end
    end

    // Memory has no reset so a loaded program survives a core reset
    always_ff @(posedge clk) begin
        if (word_end && has_room)
            mem[word_idx[ADDR_W-1:0]] <= word_asm;
    end

endmodule

// File: tb/tb_imem_loader_responder.sv
// Self-checking bench for imem_loader_responder: directed loads plus randomized
// byte streams, checked against a word-level image model of the instruction memory.
module tb_imem_loader_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 10;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   im_addr;
    logic [31:0]   im_dout;
    logic          addr_fault;
    logic          load_start;
    logic          load_valid;
    logic [7:0]    load_byte;
    logic          load_last;
    logic          load_ready;
    logic          cpu_stall;
    logic          load_busy;
    logic          load_done;
    logic          load_overflow;
    logic [AW:0]   load_count;

    int            total = 0;
    int            bad   = 0;
    logic [31:0]   ref_mem [DEPTH];
    bit            known   [DEPTH];
    int            exp_count;
    bit            exp_ovf;
    logic [7:0]    img [$];
    logic [31:0]   saved_w1;

    imem_loader_responder #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_W      (AW),
        .NOP_INSN    (NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .im_addr       (im_addr),
        .im_dout       (im_dout),
        .addr_fault    (addr_fault),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_byte     (load_byte),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .cpu_stall     (cpu_stall),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .load_overflow (load_overflow),
        .load_count    (load_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected memory image: bytes packed little-endian, final partial word zero-padded
    // only when the image ends with load_last; words past DEPTH are dropped.
    task automatic model_load(input bit has_last);
        int n;
        int nw;
        logic [31:0] word;
        n  = img.size();
        nw = has_last ? (n + 3) / 4 : n / 4;
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int b = 0; b < 4; b++)
                if (w * 4 + b < n)
                    word[b*8 +: 8] = img[w*4 + b];
            if (w < int'(DEPTH)) begin
                ref_mem[w] = word;
                known[w]   = 1'b1;
            end
        end
        exp_count = (nw < int'(DEPTH)) ? nw : int'(DEPTH);
        exp_ovf   = (nw > int'(DEPTH));
    endtask

    task automatic verify_mem();
        for (int w = 0; w < int'(DEPTH); w++) begin
            if (known[w]) begin
                im_addr = 64'(w) << 2;
                #1;
                check($sformatf("mem[%0d]", w), im_dout, ref_mem[w]);
            end
        end
    endtask

    // stop_after >= 0 leaves the loader in LOAD after that many accepted bytes
    task automatic run_load(input bit rand_valid, input bit has_last, input int stop_after);
        int n;
        int lim;
        int idx;
        int cycles;
        n   = img.size();
        lim = (stop_after >= 0) ? stop_after : n;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("count_cleared", load_count, 0);
        check("ovf_cleared", load_overflow, 0);
        check("busy_after_start", load_busy, 1);
        idx    = 0;
        cycles = 0;
        while (idx < lim) begin
            load_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            load_byte  = img[idx];
            load_last  = has_last && (idx == n - 1);
            load_start = ($urandom_range(0, 7) == 0);
            im_addr    = 64'($urandom_range(0, DEPTH - 1)) << 2;
            #1;
            check("nop_in_load", im_dout, NOP);
            check("stall_in_load", cpu_stall, 1);
            check("ready_in_load", load_ready, 1);
            step();
            if (load_valid)
                idx++;
            cycles++;
            if (cycles > 20000) begin
                check("load_timeout", cycles, 20000);
                break;
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_start = 1'b0;
        if (has_last && stop_after < 0) begin
            check("done_pulse", load_done, 1);
            check("stall_in_done", cpu_stall, 1);
            check("ready_in_done", load_ready, 0);
            check("nop_in_done", im_dout, NOP);
            step();
            check("done_single", load_done, 0);
            check("stall_released", cpu_stall, 0);
            check("busy_released", load_busy, 0);
        end
    endtask

    initial begin
        reset      = 1'b0;
        im_addr    = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_byte  = '0;
        load_last  = 1'b0;
        for (int w = 0; w < int'(DEPTH); w++)
            known[w] = 1'b0;
        #12;
        check("rst_stall", cpu_stall, 0);
        check("rst_ready", load_ready, 0);
        check("rst_done", load_done, 0);
        check("rst_busy", load_busy, 0);
        check("rst_count", load_count, 0);
        check("rst_ovf", load_overflow, 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Preload word 0 and read it back through the fetch port
        img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(1'b0, 1'b1, -1);
        model_load(1'b1);
        im_addr = 64'h0;
        #1;
        check("read0", im_dout, 32'hDEADBEEF);
        check("read0_fault", addr_fault, 0);
        check("read0_stall", cpu_stall, 0);
        check("read0_ready", load_ready, 0);

        // Fault addresses
        im_addr = 64'h2;
        #1;
        check("misaligned_fault", addr_fault, 1);
        check("misaligned_nop", im_dout, NOP);
        im_addr = 64'h1000;
        #1;
        check("range_fault", addr_fault, 1);
        check("range_nop", im_dout, NOP);
        im_addr = 64'h8000_0000_0000_0FFC;
        #1;
        check("high_bit_fault", addr_fault, 1);
        im_addr = 64'h0FFC;
        #1;
        check("last_word_no_fault", addr_fault, 0);

        // Two-word program
        img = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(1'b0, 1'b1, -1);
        model_load(1'b1);
        check("prog_count", load_count, 2);
        check("prog_ovf", load_overflow, 0);
        im_addr = 64'h0;
        #1;
        check("prog_w0", im_dout, 32'h00A00513);
        im_addr = 64'h4;
        #1;
        check("prog_w1", im_dout, 32'h00100093);

        // Padded final word
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_load(1'b0, 1'b1, -1);
        model_load(1'b1);
        check("pad_count", load_count, 2);
        im_addr = 64'h0;
        #1;
        check("pad_w0", im_dout, 32'h44332211);
        im_addr = 64'h4;
        #1;
        check("pad_w1", im_dout, 32'h00000055);

        // Random short images with gappy valid
        for (int t = 0; t < 4; t++) begin
            img.delete();
            for (int k = 0; k < int'($urandom_range(1, 40)); k++)
                img.push_back(8'($urandom));
            run_load(1'b1, 1'b1, -1);
            model_load(1'b1);
            check("rand_count", load_count, exp_count);
            check("rand_ovf", load_overflow, exp_ovf);
            verify_mem();
        end

        // Overflowing image: one word past capacity
        img.delete();
        for (int k = 0; k < int'(4 * DEPTH + 4); k++)
            img.push_back(8'($urandom));
        run_load(1'b1, 1'b1, -1);
        model_load(1'b1);
        check("ovf_count", load_count, 1024);
        check("ovf_flag", load_overflow, 1);
        verify_mem();

        // Reset after six bytes: first word kept, partial second word discarded
        saved_w1 = ref_mem[1];
        img.delete();
        for (int k = 0; k < 6; k++)
            img.push_back(8'($urandom));
        run_load(1'b1, 1'b0, 6);
        reset = 1'b0;
        #1;
        check("midrst_stall", cpu_stall, 0);
        check("midrst_count", load_count, 0);
        check("midrst_ovf", load_overflow, 0);
        check("midrst_ready", load_ready, 0);
        check("midrst_busy", load_busy, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        model_load(1'b0);
        im_addr = 64'h4;
        #1;
        check("midrst_w1_kept", im_dout, saved_w1);
        verify_mem();

        // Fresh load after the abort must not see stale lanes
        img = '{8'hA1, 8'hB2, 8'hC3};
        run_load(1'b1, 1'b1, -1);
        model_load(1'b1);
        check("post_count", load_count, 1);
        im_addr = 64'h0;
        #1;
        check("post_w0", im_dout, 32'h00C3B2A1);
        verify_mem();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
